fetcher: RTL and testbench
==========================

FETCHER -- requirements
Module: fetcher

Interface
REQ-001 Parameter PROGRAM_MEM_ADDR_BITS, default 8, SHALL set the program memory address width.
REQ-002 Parameter PROGRAM_MEM_DATA_BITS, default 16, SHALL set the instruction width.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 enable  input  1  SHALL be the block enable; when low, all state and outputs hold.
REQ-006 core_state  input  3  SHALL carry the core phase: FETCH=3'b001, DECODE=3'b010.
REQ-007 current_pc  input  PROGRAM_MEM_ADDR_BITS  SHALL carry the converged block PC to fetch.
REQ-008 flush  input  1  SHALL invalidate the instruction buffer (program reload).
REQ-009 mem_read_valid  output  1  SHALL signal a program memory read request.
REQ-010 mem_read_address  output  PROGRAM_MEM_ADDR_BITS  SHALL carry the request address.
REQ-011 mem_read_ready  input  1  SHALL signal that mem_read_data is valid this cycle.
REQ-012 mem_read_data  input  PROGRAM_MEM_DATA_BITS  SHALL carry the returned instruction.
REQ-013 fetcher_state  output  3  SHALL expose the FSM state: IDLE=3'b000, FETCHING=3'b001, FETCHED=3'b010.
REQ-014 instruction  output  PROGRAM_MEM_DATA_BITS  SHALL hold the fetched instruction for the decoder.
REQ-015 hit_count, miss_count  output  16 each  SHALL count buffer hits and memory fetches.

Function
REQ-016 The block SHALL keep a one-entry instruction buffer: buf_valid, buf_tag (address), buf_data.
REQ-017 IDLE with enable and core_state==FETCH SHALL check for a hit (buf_valid and buf_tag==current_pc).
REQ-018 On a hit, next cycle: instruction<=buf_data, state FETCHED, hit_count+1, mem_read_valid stays 0.
REQ-019 On a miss, next cycle: mem_read_valid=1, mem_read_address=current_pc, state FETCHING, miss_count+1.
REQ-020 In FETCHING, mem_read_valid and mem_read_address SHALL stay stable until the cycle mem_read_ready is high.
REQ-021 In the cycle ready is sampled high: instruction<=mem_read_data, buf_tag<=address, buf_data<=data, buf_valid<=1, mem_read_valid<=0, state FETCHED.
REQ-022 Latency SHALL be 1 cycle for a hit and 1 cycle plus memory wait (minimum 2 cycles) for a miss, measured from FETCH sampled to FETCHED.
REQ-023 FETCHED SHALL return to IDLE when core_state==DECODE; instruction SHALL hold its value until the next fetch completes.
REQ-024 mem_read_ready outside FETCHING SHALL be ignored.
REQ-025 flush SHALL clear buf_valid next cycle; if flush coincides with a fill (REQ-021), flush wins (buf_valid=0), while instruction is still delivered.
REQ-026 flush SHALL NOT abort an in-flight request.
REQ-027 Counters SHALL saturate at 16'hFFFF (no wrap).
REQ-028 core_state values other than FETCH/DECODE SHALL cause no transition.

Reset
REQ-029 With reset low, asynchronously: state IDLE, mem_read_valid 0, mem_read_address 0, instruction 0, buf_valid 0, buf_tag 0, buf_data 0, both counters 0.
REQ-030 Reset asserted mid-FETCHING SHALL drop mem_read_valid immediately; a later mem_read_ready SHALL be ignored.

Structure
REQ-031 The core_state encodings, fetcher_state encodings, and counter width SHALL live in a shared package (gpu_pkg) used by the scheduler, decoder, and pc unit.
REQ-032 The block SHALL be one module; the optional buffer (tag/data/valid plus hit compare) MAY be a sub-module fetch_buffer.

Verification
REQ-033 Reset, then FETCH with pc=0x05 and memory ready after 3 cycles with data 0xA1B2 -> mem_read_valid held for 3 cycles at address 0x05; instruction=0xA1B2; FETCHED; miss_count=1.
REQ-034 DECODE, then FETCH again with pc=0x05 -> FETCHED after 1 cycle, instruction=0xA1B2, no mem_read_valid, hit_count=1.
REQ-035 flush, then FETCH pc=0x05 -> miss; memory request issued; miss_count=2.
REQ-036 flush in the same cycle as ready (pc=0x07, data 0x1234) -> instruction=0x1234, buf_valid=0; next FETCH to 0x07 misses.
REQ-037 reset low during FETCHING -> mem_read_valid=0 immediately; a stray ready after reset release -> state stays IDLE, instruction=0.
REQ-038 enable low while FETCHING with ready pulsed -> no capture, state and outputs unchanged; hit_count forced near 0xFFFF then 2 hits -> stays 0xFFFF.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared encodings for the core phase, fetcher FSM state and event-counter width.
package gpu_pkg;

  localparam int unsigned COUNTER_BITS = 16;

  typedef enum logic [2:0] {
    CORE_FETCH  = 3'b001,
    CORE_DECODE = 3'b010
  } core_state_t;

  typedef enum logic [2:0] {
    F_IDLE     = 3'b000,
    F_FETCHING = 3'b001,
    F_FETCHED  = 3'b010
  } fetcher_state_t;

  function automatic logic [COUNTER_BITS-1:0] sat_inc(input logic [COUNTER_BITS-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry instruction buffer: tag/data/valid storage with combinational hit compare.
module fetch_buffer #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 fill,
  input  logic [ADDR_BITS-1:0] fill_tag,
  input  logic [DATA_BITS-1:0] fill_data,
  input  logic [ADDR_BITS-1:0] lookup_tag,
  output logic                 hit,
  output logic [DATA_BITS-1:0] data
);

  logic                 valid_q;
  logic [ADDR_BITS-1:0] tag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data    <= '0;
    end else if (enable) begin
      if (fill) begin
        tag_q <= fill_tag;
        data  <= fill_data;
      end
      // A flush landing on the fill cycle leaves the fresh entry invalid
      if (flush)     valid_q <= 1'b0;
      else if (fill) valid_q <= 1'b1;
    end
  end

  assign hit = valid_q && (tag_q == lookup_tag);

endmodule

// File: rtl/fetcher.sv
// Instruction fetcher: serves the current PC from a one-entry buffer or program memory.
module fetcher
  import gpu_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             flush,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNTER_BITS-1:0]          hit_count,
  output logic [COUNTER_BITS-1:0]          miss_count
);

  fetcher_state_t                   state;
  logic                             buf_hit;
  logic                             buf_fill;
  logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data;

  assign buf_fill      = enable && (state == F_FETCHING) && mem_read_ready;
  assign fetcher_state = state;

  fetch_buffer #(
    .ADDR_BITS(PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS(PROGRAM_MEM_DATA_BITS)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .flush     (flush),
    .fill      (buf_fill),
    .fill_tag  (mem_read_address),
    .fill_data (mem_read_data),
    .lookup_tag(current_pc),
    .hit       (buf_hit),
    .data      (buf_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= F_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
    end else if (enable) begin
      unique case (state)
        F_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (buf_hit) begin
              instruction <= buf_data;
              hit_count   <= sat_inc(hit_count);
              state       <= F_FETCHED;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              miss_count       <= sat_inc(miss_count);
              state            <= F_FETCHING;
            end
          end
        end
        F_FETCHING: begin
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            state          <= F_FETCHED;
          end
        end
        F_FETCHED: begin
          if (core_state == CORE_DECODE) state <= F_IDLE;
        end
        default: state <= F_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher with a queue of expected delivered instructions.
module tb_fetcher;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .core_state      (core_state),
    .current_pc      (current_pc),
    .flush           (flush),
    .mem_read_valid  (mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready  (mem_read_ready),
    .mem_read_data   (mem_read_data),
    .fetcher_state   (fetcher_state),
    .instruction     (instruction),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for FETCHED, then compare against the oldest expected instruction
  task automatic deliver(input string tag);
    int n = 0;
    logic [15:0] e;
    while (fetcher_state !== 3'b010 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_reached_fetched"}, {31'd0, n < 20}, 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_instr"}, {16'd0, instruction}, {16'd0, e});
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; core_state = 3'b000; current_pc = '0;
    flush = 1'b0; mem_read_ready = 1'b0; mem_read_data = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_state", {29'd0, fetcher_state}, 32'd0);
    chk("rst_mrv", {31'd0, mem_read_valid}, 32'd0);
    chk("rst_addr", {24'd0, mem_read_address}, 32'd0);
    chk("rst_instr", {16'd0, instruction}, 32'd0);
    chk("rst_hits", {16'd0, hit_count}, 32'd0);
    chk("rst_miss", {16'd0, miss_count}, 32'd0);
    reset = 1'b1;
    tick();

    // Miss at 0x05 with three request cycles
    core_state = CORE_FETCH; current_pc = 8'h05; exp_q.push_back(16'hA1B2);
    tick();
    core_state = 3'b000;
    chk("m1_state", {29'd0, fetcher_state}, 32'd1);
    chk("m1_miss", {16'd0, miss_count}, 32'd1);
    for (int i = 0; i < 2; i++) begin
      chk("m1_mrv_hold", {31'd0, mem_read_valid}, 32'd1);
      chk("m1_addr_hold", {24'd0, mem_read_address}, 32'h05);
      tick();
    end
    chk("m1_mrv_3rd", {31'd0, mem_read_valid}, 32'd1);
    mem_read_ready = 1'b1; mem_read_data = 16'hA1B2;
    tick();
    mem_read_ready = 1'b0;
    chk("m1_mrv_drop", {31'd0, mem_read_valid}, 32'd0);
    deliver("m1");

    // Stray ready while FETCHED is ignored
    mem_read_ready = 1'b1; mem_read_data = 16'hFFFF;
    tick();
    mem_read_ready = 1'b0;
    chk("stray_instr", {16'd0, instruction}, 32'hA1B2);
    chk("stray_state", {29'd0, fetcher_state}, 32'd2);

    // Unknown core phase causes no transition
    core_state = 3'b100;
    tick();
    chk("bad_phase_state", {29'd0, fetcher_state}, 32'd2);

    // Hit at 0x05, one cycle
    core_state = CORE_DECODE;
    tick();
    chk("dec_idle", {29'd0, fetcher_state}, 32'd0);
    core_state = CORE_FETCH; exp_q.push_back(16'hA1B2);
    tick();
    core_state = 3'b000;
    chk("h1_state", {29'd0, fetcher_state}, 32'd2);
    chk("h1_mrv", {31'd0, mem_read_valid}, 32'd0);
    chk("h1_hits", {16'd0, hit_count}, 32'd1);
    deliver("h1");

    // Flush then refetch 0x05 misses; minimum 2-cycle miss latency
    core_state = CORE_DECODE;
    tick();
    core_state = 3'b000; flush = 1'b1;
    tick();
    flush = 1'b0; core_state = CORE_FETCH; exp_q.push_back(16'hA1B2);
    tick();
    core_state = 3'b000;
    chk("m2_state", {29'd0, fetcher_state}, 32'd1);
    chk("m2_mrv", {31'd0, mem_read_valid}, 32'd1);
    chk("m2_miss", {16'd0, miss_count}, 32'd2);
    mem_read_ready = 1'b1; mem_read_data = 16'hA1B2;
    tick();
    mem_read_ready = 1'b0;
    chk("m2_latency", {29'd0, fetcher_state}, 32'd2);
    deliver("m2");

    // Flush coinciding with fill at 0x07
    core_state = CORE_DECODE;
    tick();
    core_state = CORE_FETCH; current_pc = 8'h07; exp_q.push_back(16'h1234);
    tick();
    core_state = 3'b000;
    chk("m3_miss", {16'd0, miss_count}, 32'd3);
    mem_read_ready = 1'b1; mem_read_data = 16'h1234; flush = 1'b1;
    tick();
    mem_read_ready = 1'b0; flush = 1'b0;
    deliver("m3");
    core_state = CORE_DECODE;
    tick();
    core_state = CORE_FETCH;
    tick();
    core_state = 3'b000;
    chk("m3_refetch_state", {29'd0, fetcher_state}, 32'd1);
    chk("m3_refetch_mrv", {31'd0, mem_read_valid}, 32'd1);
    chk("m3_refetch_miss", {16'd0, miss_count}, 32'd4);
    exp_q.push_back(16'h1234);
    mem_read_ready = 1'b1; mem_read_data = 16'h1234;
    tick();
    mem_read_ready = 1'b0;
    deliver("m4");

    // Reset in the middle of FETCHING
    core_state = CORE_DECODE;
    tick();
    core_state = CORE_FETCH; current_pc = 8'h09;
    tick();
    core_state = 3'b000;
    chk("rf_fetching", {29'd0, fetcher_state}, 32'd1);
    reset = 1'b0;
    #1;
    chk("rf_mrv_async", {31'd0, mem_read_valid}, 32'd0);
    chk("rf_state_async", {29'd0, fetcher_state}, 32'd0);
    @(negedge clk);
    reset = 1'b1; mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    tick();
    mem_read_ready = 1'b0;
    chk("rf_stray_state", {29'd0, fetcher_state}, 32'd0);
    chk("rf_stray_instr", {16'd0, instruction}, 32'd0);

    // Enable low freezes FETCHING even with ready
    core_state = CORE_FETCH; current_pc = 8'h03;
    tick();
    core_state = 3'b000;
    enable = 1'b0; mem_read_ready = 1'b1; mem_read_data = 16'h5555;
    tick(); tick();
    chk("en_state", {29'd0, fetcher_state}, 32'd1);
    chk("en_mrv", {31'd0, mem_read_valid}, 32'd1);
    chk("en_addr", {24'd0, mem_read_address}, 32'h03);
    chk("en_instr", {16'd0, instruction}, 32'd0);
    chk("en_miss", {16'd0, miss_count}, 32'd1);
    enable = 1'b1; exp_q.push_back(16'h5555);
    tick();
    mem_read_ready = 1'b0;
    deliver("en");

    // Hit counter saturation
    core_state = CORE_DECODE;
    tick();
    core_state = 3'b000; enable = 1'b0;
    force dut.hit_count = 16'hFFFE;
    tick();
    release dut.hit_count;
    enable = 1'b1;
    tick();
    chk("sat_preset", {16'd0, hit_count}, 32'hFFFE);
    for (int i = 0; i < 2; i++) begin
      core_state = CORE_FETCH; exp_q.push_back(16'h5555);
      tick();
      deliver("sat_hit");
      chk("sat_hits", {16'd0, hit_count}, 32'hFFFF);
      core_state = CORE_DECODE;
      tick();
    end
    chk("sat_miss_unchanged", {16'd0, miss_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
